lfsr_hd_stats: RTL and testbench
================================

# lfsr_hd_stats

Parametrised successor to the fixed 8-bit LFSR/Hamming-distance datapath. It runs a WIDTH-bit Galois-style LFSR with a run-time tap mask and seed for a commanded number of steps. Every state is streamed to an external data-memory write port, and the per-step Hamming distance (HD) is accumulated. At the end, the integer average HD and its remainder are produced by an on-block sequential divider. The block sits beside the instruction-driven core as a self-timed pattern-generation engine with a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, LFSR width (≥ 2)
- CNT_W, 16, step-count width
- AW, 8, memory address width
- Derived (localparam): HDW = $clog2(WIDTH+1); ACC_W = CNT_W + HDW

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse, sampled only while busy=0
- seed  in  WIDTH  initial LFSR state
- taps  in  WIDTH  feedback mask; bit k (k≥1) set: q[k] <= q[k-1]^q[WIDTH-1]; bit 0 ignored
- n_steps  in  CNT_W  number of LFSR steps
- base_addr  in  AW  first write address
- busy  out  1  run or divide in progress
- done  out  1  one-cycle pulse, results valid
- lfsr_q  out  WIDTH  current LFSR state
- hd  out  HDW  HD of the most recent step
- hd_total  out  ACC_W  accumulated HD
- avg  out  HDW  floor(hd_total / n_steps)
- avg_rem  out  CNT_W  hd_total mod n_steps
- mem_we, mem_addr[AW], mem_wdata[WIDTH]  out  registered memory write port

## Operation
- FSM states: IDLE, RUN, DIV. IDLE→RUN on start, or IDLE→DIV if n_steps=0. RUN→DIV after n_steps steps. DIV→IDLE after ACC_W iterations.
- On start, latch seed, taps, n_steps and base_addr. hd_total, hd, avg, avg_rem and the step counter are cleared.
- Seed 0 is latched as 1 to avoid lock-up.
- Step function: next[0] = q[WIDTH-1]; for k≥1, next[k] = q[k-1] ^ (taps[k] & q[WIDTH-1]).
- Each RUN cycle, i = 0..n_steps-1:
  - lfsr_q <= next
  - hd <= popcount(q ^ next)
  - hd_total += that popcount
  - mem_we <= 1, mem_addr <= base_addr + i (mod 2^AW, wraps), mem_wdata <= next
- mem_we is 0 in every other cycle.
- DIV: restoring division of hd_total by latched n_steps, one quotient bit per cycle, ACC_W cycles. avg takes the low HDW quotient bits (quotient ≤ WIDTH by construction).
- Divisor 0: avg=0, avg_rem=0, with the same latency.
- start while busy=1 is ignored. taps and seed changes during a run have no effect.
- lfsr_q, hd, hd_total, avg and avg_rem hold their values in IDLE until the next start.
- Reset at any time: every output goes to 0 at the next edge, FSM to IDLE. An in-flight run is abandoned with no done pulse.

## Timing
- Edge E0 samples start. busy=1 from the cycle after E0 until the end of DIV.
- RUN occupies cycles 1..N. mem_we=1 in cycles 2..N+1 and is aligned with the lfsr_q update, so mem_wdata equals lfsr_q.
- DIV occupies cycles N+1..N+ACC_W.
- done=1 in cycle N+ACC_W+1 only, with busy=0 and all results valid. A new start is accepted in that same cycle.
- Reset values: busy=0, done=0, lfsr_q=0, hd=0, hd_total=0, avg=0, avg_rem=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Structure
- Package lfsr_pkg:
  - FSM state enum
  - step function lfsr_next(q, taps)
  - popcount function
- One sub-module: lfsr_seq_div, a parametrised restoring divider with start/done handshake, reused by later statistics blocks.

## Test plan
- WIDTH=8, seed=0x80, taps=0x1C, n_steps=1 -> lfsr_q=0x1D, hd=5, hd_total=5, avg=5, avg_rem=0, one write of 0x1D at base_addr.
- seed=0x01, taps=0x00, n_steps=8 -> lfsr_q walks 0x02,0x04,…,0x80,0x01; hd=2 each step; hd_total=16, avg=2, avg_rem=0; done exactly 8+ACC_W+1 cycles after start.
- n_steps=0 -> no mem_we, avg=0, avg_rem=0, done at cycle ACC_W+1.
- base_addr=0xFE, n_steps=4 -> writes to 0xFE, 0xFF, 0x00, 0x01 in order. Also seed=0x00 -> first state computed from 0x01.
- Second start pulsed mid-RUN with different seed -> ignored, results match the first run. Also reset asserted mid-RUN -> all outputs 0 next cycle, no done pulse.
- Random seeds/taps/n_steps, WIDTH=8 and WIDTH=16 -> lfsr_q, hd_total, avg and avg_rem match a reference model.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared FSM type and datapath helpers for the LFSR Hamming-distance statistics engine.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;
  localparam int LFSR_IDX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DIV  = 2'd2
  } lfsr_state_e;

  // Galois step on the low 'width' bits; bit 0 of the tap mask never feeds back.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] q,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic                  msb;
    logic [LFSR_IDX_W-1:0] msb_idx;
    logic [LFSR_MAX_W-1:0] nxt;
    msb_idx = LFSR_IDX_W'(width - 1);
    msb     = q[msb_idx];
    nxt     = '0;
    nxt[0]  = msb;
    for (int k = 1; k < LFSR_MAX_W; k++) begin
      if (k < width) nxt[k] = q[k-1] ^ (taps[k] & msb);
      else nxt[k] = 1'b0;
    end
    return nxt;
  endfunction

  function automatic logic [7:0] popcount(input logic [LFSR_MAX_W-1:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int k = 0; k < LFSR_MAX_W; k++) cnt = cnt + {7'd0, v[k]};
    return cnt;
  endfunction

endpackage

// File: rtl/lfsr_seq_div.sv
// Restoring divider producing one quotient bit per cycle; done pulses DW cycles after start.
// A zero divisor yields zero quotient and remainder with the same latency.
module lfsr_seq_div #(
  parameter int DW = 20,
  parameter int VW = 16,
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          done_o,
  output logic [QW-1:0] quot_o,
  output logic [VW-1:0] rem_o
);
  localparam int CW = $clog2(DW + 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] part_q;
  logic [VW-1:0] dvs_q;
  logic          done_q;
  logic [QW-1:0] quot_q;
  logic [VW-1:0] rem_q;

  logic [VW:0]   shift_s;
  logic          ge_s;
  logic [VW-1:0] part_nxt_s;
  logic [DW-1:0] dvd_nxt_s;
  logic          last_s;

  // One restoring iteration: the dividend register shifts the quotient bits in from the right.
  always_comb begin
    shift_s = {part_q, dvd_q[DW-1]};
    ge_s    = (shift_s >= {1'b0, dvs_q});
    if (ge_s) part_nxt_s = shift_s[VW-1:0] - dvs_q;
    else part_nxt_s = shift_s[VW-1:0];
    dvd_nxt_s = {dvd_q[DW-2:0], ge_s};
    last_s    = (cnt_q == CW'(DW - 1));
  end

  // Iteration sequencing and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      part_q <= '0;
      dvs_q  <= '0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (clr_i) begin
        quot_q <= '0;
        rem_q  <= '0;
      end
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        dvd_q  <= dividend_i;
        part_q <= '0;
        dvs_q  <= divisor_i;
      end else if (busy_q) begin
        part_q <= part_nxt_s;
        dvd_q  <= dvd_nxt_s;
        cnt_q  <= cnt_q + CW'(1);
        if (last_s) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (dvs_q == '0) begin
            quot_q <= '0;
            rem_q  <= '0;
          end else begin
            quot_q <= dvd_nxt_s[QW-1:0];
            rem_q  <= part_nxt_s;
          end
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/lfsr_hd_stats.sv
// Self-timed LFSR pattern engine: streams each state to a memory write port and reports
// the accumulated and average per-step Hamming distance.
module lfsr_hd_stats
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int AW    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   seed,
  input  logic [WIDTH-1:0]                   taps,
  input  logic [CNT_W-1:0]                   n_steps,
  input  logic [AW-1:0]                      base_addr,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH-1:0]                   lfsr_q,
  output logic [$clog2(WIDTH+1)-1:0]         hd,
  output logic [CNT_W+$clog2(WIDTH+1)-1:0]   hd_total,
  output logic [$clog2(WIDTH+1)-1:0]         avg,
  output logic [CNT_W-1:0]                   avg_rem,
  output logic                               mem_we,
  output logic [AW-1:0]                      mem_addr,
  output logic [WIDTH-1:0]                   mem_wdata
);
  localparam int HDW   = $clog2(WIDTH + 1);
  localparam int ACC_W = CNT_W + HDW;

  lfsr_state_e      state_q;
  logic [WIDTH-1:0] lfsr_st_q;
  logic [WIDTH-1:0] taps_q;
  logic [CNT_W-1:0] nsteps_q;
  logic [AW-1:0]    base_q;
  logic [CNT_W-1:0] cnt_q;
  logic [HDW-1:0]   hd_q;
  logic [ACC_W-1:0] tot_q;
  logic             busy_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic [WIDTH-1:0] lfsr_nxt_s;
  logic [HDW-1:0]   hd_step_s;
  logic [ACC_W-1:0] tot_d;
  logic             last_step_s;
  logic             div_clr_s;
  logic             div_start_s;
  logic [ACC_W-1:0] div_dvd_s;
  logic [CNT_W-1:0] div_dvs_s;

  // Step datapath and divider launch; the final step's HD is forwarded straight into the divider.
  always_comb begin
    lfsr_nxt_s  = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_st_q), LFSR_MAX_W'(taps_q), WIDTH));
    hd_step_s   = HDW'(popcount(LFSR_MAX_W'(lfsr_st_q ^ lfsr_nxt_s)));
    tot_d       = tot_q + ACC_W'(hd_step_s);
    last_step_s = (cnt_q == nsteps_q - CNT_W'(1));
    div_clr_s   = 1'b0;
    div_start_s = 1'b0;
    div_dvd_s   = '0;
    div_dvs_s   = '0;
    if (state_q == ST_IDLE) begin
      div_clr_s   = start;
      div_start_s = start && (n_steps == '0);
    end else if (state_q == ST_RUN) begin
      div_start_s = last_step_s;
      div_dvd_s   = tot_d;
      div_dvs_s   = nsteps_q;
    end else begin
      div_start_s = 1'b0;
    end
  end

  // Control FSM with registered status, statistics and memory-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lfsr_st_q <= '0;
      taps_q    <= '0;
      nsteps_q  <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      hd_q      <= '0;
      tot_q     <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            lfsr_st_q <= (seed == '0) ? WIDTH'(1'b1) : seed;
            taps_q    <= taps;
            nsteps_q  <= n_steps;
            base_q    <= base_addr;
            hd_q      <= '0;
            tot_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= (n_steps == '0) ? ST_DIV : ST_RUN;
          end
        end
        ST_RUN: begin
          lfsr_st_q <= lfsr_nxt_s;
          hd_q      <= hd_step_s;
          tot_q     <= tot_d;
          we_q      <= 1'b1;
          addr_q    <= base_q + AW'(cnt_q);
          wdata_q   <= lfsr_nxt_s;
          if (last_step_s) begin
            cnt_q   <= '0;
            state_q <= ST_DIV;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DIV: begin
          // Mirrors the divider's iteration count so busy drops on the edge that raises done.
          if (cnt_q == CNT_W'(ACC_W - 1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  lfsr_seq_div #(
    .DW(ACC_W),
    .VW(CNT_W),
    .QW(HDW)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (div_clr_s),
    .start_i    (div_start_s),
    .dividend_i (div_dvd_s),
    .divisor_i  (div_dvs_s),
    .done_o     (done),
    .quot_o     (avg),
    .rem_o      (avg_rem)
  );

  assign busy      = busy_q;
  assign lfsr_q    = lfsr_st_q;
  assign hd        = hd_q;
  assign hd_total  = tot_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lfsr_hd_stats.sv
// Bench for lfsr_hd_stats: table vectors, handshake corner cases and randomized runs at
// WIDTH=8 and WIDTH=16, checked against a behavioural model of the pattern engine.
module tb_lfsr_hd_stats;
  localparam int ACC8  = 16 + $clog2(8 + 1);
  localparam int ACC16 = 16 + $clog2(16 + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_start, sel16;
  logic [15:0] in_seed, in_taps, in_n;
  logic [7:0]  in_base;

  logic        busy8, done8, we8;
  logic [7:0]  lfsr8, addr8, wd8;
  logic [3:0]  hd8, avg8;
  logic [19:0] tot8;
  logic [15:0] rem8;

  logic        busy16, done16, we16;
  logic [15:0] lfsr16, wd16, rem16;
  logic [7:0]  addr16;
  logic [4:0]  hd16, avg16;
  logic [20:0] tot16;

  lfsr_hd_stats #(.WIDTH(8), .CNT_W(16), .AW(8)) dut8 (
    .clk(clk), .reset(reset), .start(in_start & ~sel16), .seed(in_seed[7:0]),
    .taps(in_taps[7:0]), .n_steps(in_n), .base_addr(in_base), .busy(busy8), .done(done8),
    .lfsr_q(lfsr8), .hd(hd8), .hd_total(tot8), .avg(avg8), .avg_rem(rem8),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8));

  lfsr_hd_stats #(.WIDTH(16), .CNT_W(16), .AW(8)) dut16 (
    .clk(clk), .reset(reset), .start(in_start & sel16), .seed(in_seed),
    .taps(in_taps), .n_steps(in_n), .base_addr(in_base), .busy(busy16), .done(done16),
    .lfsr_q(lfsr16), .hd(hd16), .hd_total(tot16), .avg(avg16), .avg_rem(rem16),
    .mem_we(we16), .mem_addr(addr16), .mem_wdata(wd16));

  logic        v_busy, v_done, v_we;
  logic [15:0] v_lfsr, v_wd, v_rem;
  logic [7:0]  v_addr;
  int          v_hd, v_tot, v_avg;

  always_comb begin
    if (sel16) begin
      v_busy = busy16; v_done = done16; v_we = we16; v_lfsr = lfsr16; v_wd = wd16;
      v_rem = rem16; v_addr = addr16; v_hd = int'(hd16); v_tot = int'(tot16); v_avg = int'(avg16);
    end else begin
      v_busy = busy8; v_done = done8; v_we = we8; v_lfsr = {8'h00, lfsr8}; v_wd = {8'h00, wd8};
      v_rem = rem8; v_addr = addr8; v_hd = int'(hd8); v_tot = int'(tot8); v_avg = int'(avg8);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] m_lfsr;
  int          m_hd, m_tot, m_avg, m_rem;

  // Reference: shift left, fold the tap mask in when the old MSB was set, then divide.
  task automatic model(input int w, input logic [15:0] seed, input logic [15:0] taps,
                       input int n, input logic [7:0] base);
    int mask, q, nx;
    mask = (1 << w) - 1;
    q = int'(seed) & mask;
    if (q == 0) q = 1;
    exp_wr.delete();
    m_hd = 0; m_tot = 0;
    for (int i = 0; i < n; i++) begin
      nx = (q << 1) & mask;
      if (((q >> (w - 1)) & 1) != 0) nx = (nx ^ (int'(taps) & mask & ~1)) | 1;
      m_hd = $countones(q ^ nx);
      m_tot += m_hd;
      exp_wr.push_back('{addr: 8'((int'(base) + i) % 256), data: 16'(nx)});
      q = nx;
    end
    m_lfsr = 16'(q);
    m_avg = (n == 0) ? 0 : m_tot / n;
    m_rem = (n == 0) ? 0 : m_tot % n;
  endtask

  task automatic launch(input int w, input logic [15:0] seed, input logic [15:0] taps,
                        input int n, input logic [7:0] base);
    sel16 = (w == 16); in_seed = seed; in_taps = taps; in_n = 16'(n); in_base = base;
    in_start = 1'b1;
    model(w, seed, taps, n, base);
  endtask

  // Follows one run from the cycle after the start edge until done (or a cycle budget).
  task automatic track(input string tag, input int w, input int n, input int restart_at);
    int acc, nw, bad, done_cyc;
    logic busy_at_done;
    acc = (w == 16) ? ACC16 : ACC8;
    nw = 0; bad = 0; done_cyc = -1; busy_at_done = 1'b1;
    for (int k = 1; k <= n + acc + 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      in_start = (k == restart_at);
      if (k == restart_at) begin
        in_seed = 16'h0001; in_taps = 16'h0000; in_n = 16'd5;
      end else begin
        in_seed = 16'($urandom); in_taps = 16'($urandom);
      end
      if (v_we) begin
        if (k < 2 || k > n + 1) bad++;
        if (nw < exp_wr.size()) begin
          check({tag, "/wr_addr"}, 64'(v_addr), 64'(exp_wr[nw].addr));
          check({tag, "/wr_data"}, 64'(v_wd), 64'(exp_wr[nw].data));
        end
        nw++;
      end
      if (v_done) begin
        done_cyc = k; busy_at_done = v_busy;
      end else if (!v_busy) begin
        bad++;
      end
    end
    in_start = 1'b0;
    check({tag, "/done_cycle"}, 64'(done_cyc), 64'(n + acc + 1));
    check({tag, "/busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, "/timing_violations"}, 64'(bad), 64'd0);
    check({tag, "/write_count"}, 64'(nw), 64'(exp_wr.size()));
    check({tag, "/lfsr_q"}, 64'(v_lfsr), 64'(m_lfsr));
    check({tag, "/hd"}, 64'(v_hd), 64'(m_hd));
    check({tag, "/hd_total"}, 64'(v_tot), 64'(m_tot));
    check({tag, "/avg"}, 64'(v_avg), 64'(m_avg));
    check({tag, "/avg_rem"}, 64'(v_rem), 64'(m_rem));
  endtask

  task automatic do_run(input string tag, input int w, input logic [15:0] seed,
                        input logic [15:0] taps, input int n, input logic [7:0] base,
                        input int restart_at);
    @(negedge clk);
    launch(w, seed, taps, n, base);
    track(tag, w, n, restart_at);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/busy"}, 64'(v_busy), 64'd0);
    check({tag, "/done"}, 64'(v_done), 64'd0);
    check({tag, "/lfsr_hd"}, {32'(v_lfsr), 32'(v_hd)}, 64'd0);
    check({tag, "/stats"}, {v_tot, v_avg}, 64'd0);
    check({tag, "/avg_rem"}, 64'(v_rem), 64'd0);
    check({tag, "/mem_port"}, {39'd0, v_we, v_addr, v_wd}, 64'd0);
  endtask

  typedef struct {
    int w; logic [15:0] seed; logic [15:0] taps; int n; logic [7:0] base; int restart_at;
    logic [15:0] e_lfsr; int e_hd; int e_tot; int e_avg; int e_rem;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int nd, nwr;
    vecs[0] = '{8,  16'h0080, 16'h001C, 1,  8'h10, 0, 16'h001D, 5, 5,  5, 0};
    vecs[1] = '{8,  16'h0001, 16'h0000, 8,  8'h00, 0, 16'h0001, 2, 16, 2, 0};
    vecs[2] = '{8,  16'h0055, 16'h001C, 0,  8'h33, 0, 16'h0055, 0, 0,  0, 0};
    vecs[3] = '{8,  16'h0000, 16'h0000, 4,  8'hFE, 0, 16'h0010, 2, 8,  2, 0};
    vecs[4] = '{8,  16'h0080, 16'h001C, 3,  8'h20, 2, 16'h0074, 4, 13, 4, 1};
    vecs[5] = '{16, 16'h8000, 16'h0002, 1,  8'h80, 0, 16'h0003, 3, 3,  3, 0};
    vecs[6] = '{16, 16'h0000, 16'h0000, 16, 8'hF8, 0, 16'h0001, 2, 32, 2, 0};

    in_start = 1'b0; sel16 = 1'b0; in_seed = '0; in_taps = '0; in_n = '0; in_base = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset8");
    sel16 = 1'b1; #1;
    check_all_zero("reset16");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_run($sformatf("vec%0d", i), vecs[i].w, vecs[i].seed, vecs[i].taps, vecs[i].n,
             vecs[i].base, vecs[i].restart_at);
      check($sformatf("vec%0d/tbl_lfsr", i), 64'(v_lfsr), 64'(vecs[i].e_lfsr));
      check($sformatf("vec%0d/tbl_hd", i), 64'(v_hd), 64'(vecs[i].e_hd));
      check($sformatf("vec%0d/tbl_total", i), 64'(v_tot), 64'(vecs[i].e_tot));
      check($sformatf("vec%0d/tbl_avg_rem", i), {32'(v_avg), 32'(v_rem)},
            {32'(vecs[i].e_avg), 32'(vecs[i].e_rem)});
    end

    // New start raised in the done cycle of the previous run must be accepted.
    launch(16, 16'h1234, 16'h100B, 12, 8'hFC);
    track("b2b", 16, 12, 0);

    // Reset in the middle of a run: everything clears and the run never completes.
    do_run("pre_reset", 8, 16'h00A5, 16'h001C, 5, 8'h40, 0);
    @(negedge clk);
    launch(8, 16'h00A5, 16'h001C, 10, 8'h40);
    @(negedge clk);
    in_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    nd = 0; nwr = 0;
    for (int k = 0; k < ACC8 + 20; k++) begin
      @(negedge clk);
      if (v_done) nd++;
      if (v_we || v_busy) nwr++;
    end
    check("mid_reset/no_done", 64'(nd), 64'd0);
    check("mid_reset/stays_idle", 64'(nwr), 64'd0);

    for (int i = 0; i < 24; i++) begin
      do_run($sformatf("rnd%0d", i), (i % 2 == 1) ? 16 : 8, 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 40)), 8'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
